// File: rtl/simon_sequencer.sv
// simon_sequencer: memory-game controller that grows, plays back and checks a random colour sequence.
// Optional INPUT_TIMEOUT_EN macro adds a per-press timeout counted in timer pulses.
module simon_sequencer #(
  parameter int COLOR_W = 2,
  parameter int MAX_LEN = 32,
  parameter int CNT_W = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT_PULSES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] in_i,
  input  logic               in_valid_i,
  input  logic [COLOR_W-1:0] rand_i,
  input  logic               timer_pulse_i,
  input  logic               start_game_i,
  output logic [COLOR_W-1:0] out_o,
  output logic               out_ena_o,
  output logic               timer_go_o,
  output logic               win_o,
  output logic               lose_o,
  output logic               hs_o,
  output logic [CNT_W-1:0]   score_o,
  output logic [CNT_W-1:0]   high_score_o,
  output logic               busy_o
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [2:0] {IDLE, ADD, SHOW, SHOW_WAIT, INPUT, END_WIN, END_LOSE} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q, i_q, score_q, high_q;
  logic [COLOR_W-1:0] out_q;
  logic out_ena_q, timer_go_q, win_q, lose_q, hs_q;
  logic [COLOR_W-1:0] stack_q [MAX_LEN];
  logic last, hit;
`ifdef INPUT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_PULSES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_PULSES - 1);
  logic [TMO_W-1:0] tmo_q;
`endif
  assign last = i_q == cnt_q - ONE;
  assign hit = in_i == stack_q[i_q[IDX_W-1:0]];
  // Sequence storage carries no reset; only entries below cnt are ever read.
  always_ff @(posedge clk)
    if (state_q == ADD && cnt_q != LEN) stack_q[cnt_q[IDX_W-1:0]] <= rand_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      i_q <= '0;
      score_q <= '0;
      high_q <= '0;
      out_q <= '1;
      out_ena_q <= 1'b0;
      timer_go_q <= 1'b0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
      hs_q <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      timer_go_q <= 1'b0;
      hs_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          i_q <= '0;
          out_ena_q <= 1'b0;
          if (start_game_i) begin
            win_q <= 1'b0;
            lose_q <= 1'b0;
            score_q <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          if (cnt_q == LEN) state_q <= END_WIN;
          else begin
            cnt_q <= cnt_q + ONE;
            i_q <= '0;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          out_q <= stack_q[i_q[IDX_W-1:0]];
          out_ena_q <= 1'b1;
          timer_go_q <= 1'b1;
          state_q <= SHOW_WAIT;
        end
        SHOW_WAIT: begin
          if (timer_pulse_i) begin
            out_ena_q <= 1'b0;
            if (last) begin
              i_q <= '0;
              state_q <= INPUT;
`ifdef INPUT_TIMEOUT_EN
              timer_go_q <= 1'b1;
              tmo_q <= '0;
`endif
            end else begin
              i_q <= i_q + ONE;
              state_q <= SHOW;
            end
          end
        end
        INPUT: begin
          // A press in the same cycle as the final timeout pulse takes priority.
          if (in_valid_i) begin
            if (!hit) state_q <= END_LOSE;
            else if (last) begin
              score_q <= cnt_q;
              state_q <= ADD;
            end else begin
              i_q <= i_q + ONE;
`ifdef INPUT_TIMEOUT_EN
              timer_go_q <= 1'b1;
              tmo_q <= '0;
`endif
            end
          end
`ifdef INPUT_TIMEOUT_EN
          else if (timer_pulse_i) begin
            if (tmo_q == TMO_LAST) state_q <= END_LOSE;
            else tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        END_WIN, END_LOSE: begin
          if (state_q == END_WIN) win_q <= 1'b1;
          else lose_q <= 1'b1;
          if (score_q > high_q) begin
            high_q <= score_q;
            hs_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_o = out_q;
  assign out_ena_o = out_ena_q;
  assign timer_go_o = timer_go_q;
  assign win_o = win_q;
  assign lose_o = lose_q;
  assign hs_o = hs_q;
  assign score_o = score_q;
  assign high_score_o = high_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: plays randomized games against a queue-based model of the sequence and scores.
module tb_simon_sequencer;
  localparam int CW = 2;
  localparam int ML = 4;
  localparam int CNT_W = $clog2(ML + 1);
  localparam int TP = 3;
`ifdef INPUT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [CW-1:0] in_c = '0, rand_c = '0;
  logic in_valid = 1'b0, timer_pulse = 1'b0, start_game = 1'b0;
  logic [CW-1:0] out;
  logic out_ena, timer_go, win, lose, hs, busy;
  logic [CNT_W-1:0] score, high_score;
  int compared = 0, mismatched = 0;
  int score_m = 0, high_m = 0;
  logic [CW-1:0] seq[$];
  logic [CW-1:0] vals[ML];

  simon_sequencer #(.COLOR_W(CW), .MAX_LEN(ML), .TIMEOUT_PULSES(TP)) dut (
    .clk(clk), .rst_n(rst_n), .in_i(in_c), .in_valid_i(in_valid), .rand_i(rand_c),
    .timer_pulse_i(timer_pulse), .start_game_i(start_game), .out_o(out), .out_ena_o(out_ena),
    .timer_go_o(timer_go), .win_o(win), .lose_o(lose), .hs_o(hs), .score_o(score),
    .high_score_o(high_score), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [CW-1:0] c);
    in_c = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"}, out, 3);
    chk({tag, "_ena"}, out_ena, 0);
    chk({tag, "_go"}, timer_go, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_lose"}, lose, 0);
    chk({tag, "_hs"}, hs, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_high"}, high_score, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Entered with the DUT in SHOW; plays back every queued colour.
  task automatic show_round();
    int n;
    for (int k = 0; k < seq.size(); k++) begin
      n = 0;
      while (timer_go !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("go_latency", n, 1);
      chk("show_out", out, seq[k]);
      chk("show_ena", out_ena, 1);
      chk("show_busy", busy, 1);
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b1;
        in_c = CW'($urandom);
        start_game = 1'b1;
        tick();
        in_valid = 1'b0;
        start_game = 1'b0;
        chk("hold_go", timer_go, 0);
        chk("hold_ena", out_ena, 1);
      end
      timer_pulse = 1'b1;
      tick();
      timer_pulse = 1'b0;
      chk("ena_off", out_ena, 0);
      chk("go_after_pulse", timer_go, (k == seq.size() - 1) && TMO);
    end
  endtask

  // lose_at = 0 plays to a win; otherwise press wk of round lose_at is corrupted by mask.
  task automatic run_game(input int lose_at, input int wk, input logic [CW-1:0] mask);
    bit lost = 1'b0;
    bit exp_hs;
    seq.delete();
    score_m = 0;
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_win", win, 0);
    chk("start_lose", lose, 0);
    chk("start_score", score, 0);
    for (int r = 1; r <= ML && !lost; r++) begin
      rand_c = vals[r-1];
      seq.push_back(vals[r-1]);
      tick();
      rand_c = CW'($urandom);
      show_round();
      for (int k = 0; k < r && !lost; k++) begin
        if (r == lose_at && k == wk) begin
          press(seq[k] ^ mask);
          lost = 1'b1;
        end else press(seq[k]);
      end
      if (!lost) begin
        score_m = r;
        chk("round_score", score, score_m);
        chk("round_busy", busy, 1);
      end
    end
    if (!lost) tick();
    chk("end_busy", busy, 1);
    chk("end_flag_early", win | lose, 0);
    tick();
    exp_hs = score_m > high_m;
    if (exp_hs) high_m = score_m;
    chk("end_win", win, !lost);
    chk("end_lose", lose, lost);
    chk("end_score", score, score_m);
    chk("end_high", high_score, high_m);
    chk("end_hs", hs, exp_hs);
    chk("end_idle", busy, 0);
    tick();
    chk("hs_pulse_off", hs, 0);
    chk("win_hold", win, !lost);
    chk("lose_hold", lose, lost);
  endtask

  initial begin
    int la;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Directed first game: stack {2,1}, second press of round 2 is 3.
    vals[0] = 2;
    vals[1] = 1;
    vals[2] = 0;
    vals[3] = 3;
    run_game(2, 1, 2);
    // Full win, then a loss at score 2.
    for (int j = 0; j < ML; j++) vals[j] = CW'($urandom);
    run_game(0, 0, 1);
    for (int j = 0; j < ML; j++) vals[j] = CW'($urandom);
    run_game(3, $urandom_range(0, 2), CW'($urandom_range(1, 3)));
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < ML; j++) vals[j] = CW'($urandom);
      la = $urandom_range(0, ML);
      run_game(la, (la > 0) ? $urandom_range(0, la - 1) : 0, CW'($urandom_range(1, 3)));
    end
    // Asynchronous reset while waiting for a press.
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    seq.delete();
    rand_c = 0;
    seq.push_back(0);
    tick();
    show_round();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    high_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`ifdef INPUT_TIMEOUT_EN
    // No press across TP pulses loses the game.
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    seq.delete();
    rand_c = 1;
    seq.push_back(1);
    tick();
    show_round();
    for (int p = 0; p < TP; p++) begin
      chk("tmo_busy", busy, 1);
      chk("tmo_lose_early", lose, 0);
      timer_pulse = 1'b1;
      tick();
      timer_pulse = 1'b0;
    end
    tick();
    chk("tmo_lose", lose, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_score", score, 0);
    // A press coinciding with the last pulse is accepted.
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    seq.delete();
    rand_c = 2;
    seq.push_back(2);
    tick();
    show_round();
    repeat (TP - 1) begin
      timer_pulse = 1'b1;
      tick();
      timer_pulse = 1'b0;
    end
    timer_pulse = 1'b1;
    press(2);
    timer_pulse = 1'b0;
    chk("tmo_race_score", score, 1);
    chk("tmo_race_busy", busy, 1);
    tick();
    chk("tmo_race_lose", lose, 0);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Parametrised game-sequence controller for the memory game.
- Grows a random colour sequence one entry per round and plays it back through the display/sound path under an external timer.
- Checks the player's encoded presses against the sequence, then ends in win or lose.
- Tracks score and high score. Generalises colour count and sequence depth; adds score outputs, busy status and an optional input timeout.

Parameters:
- COLOR_W, 2, colour code width; number of colours = 2**COLOR_W
- MAX_LEN, 32, sequence depth; completing round MAX_LEN wins the game
- CNT_W, $clog2(MAX_LEN+1), width of counters and score outputs (derived; do not override)
- TIMEOUT_PULSES, 8, TIMER_PULSE count allowed per press (only with INPUT_TIMEOUT_EN)

Ports:
- CLK  input  1  system clock
- RST_N  input  1  reset; asynchronous, active-low
- IN  input  COLOR_W  encoded player press, already synchronised externally
- IN_VALID  input  1  one-cycle strobe; IN is valid this cycle
- RAND  input  COLOR_W  random colour, sampled in ADD
- TIMER_PULSE  input  1  one-cycle end-of-interval strobe from the external timer
- START_GAME  input  1  start request; honoured in IDLE only
- OUT  output  COLOR_W  colour being displayed
- OUT_ENA  output  1  display/sound enable
- TIMER_GO  output  1  one-cycle timer start pulse
- WIN  output  1  game won (level)
- LOSE  output  1  game lost (level)
- HS  output  1  one-cycle pulse: new high score recorded
- SCORE  output  CNT_W  rounds completed in the current or last game
- HIGH_SCORE  output  CNT_W  best SCORE since reset
- BUSY  output  1  high in every state except IDLE

Behaviour:
Reset values:
- OUT = all ones; OUT_ENA, TIMER_GO, WIN, LOSE, HS, SCORE, HIGH_SCORE = 0; state = IDLE.
- Internal indices cnt and i = 0.
- Sequence storage (MAX_LEN x COLOR_W) is not reset.
- Reset mid-game aborts immediately to these values, including HIGH_SCORE.

Defaults: TIMER_GO and HS are pulse outputs; they default to 0 every cycle unless a state sets them.

States and transitions:
- IDLE: hold cnt = 0, i = 0, OUT_ENA = 0. On START_GAME: clear WIN, LOSE, SCORE; go to ADD.
- ADD:
  - If cnt == MAX_LEN, go to END_WIN.
  - Otherwise write stack[cnt] <= RAND, cnt <= cnt+1, i <= 0; go to SHOW.
- SHOW: OUT <= stack[i], OUT_ENA <= 1, TIMER_GO <= 1; go to SHOW_WAIT.
- SHOW_WAIT: on TIMER_PULSE, OUT_ENA <= 0.
  - If i == cnt-1: i <= 0; go to INPUT.
  - Otherwise i <= i+1; go to SHOW.
  - Exactly cnt entries are shown per round.
- INPUT: on IN_VALID:
  - IN == stack[i] and i == cnt-1: SCORE <= cnt; go to ADD.
  - IN == stack[i] otherwise: i <= i+1.
  - IN != stack[i]: go to END_LOSE.
- END_WIN / END_LOSE: set WIN or LOSE.
  - If SCORE > HIGH_SCORE: HIGH_SCORE <= SCORE and HS pulse for one cycle.
  - Go to IDLE next cycle.
  - WIN and LOSE stay high until the next accepted START_GAME.

Ignored events:
- START_GAME outside IDLE.
- IN_VALID outside INPUT.
- TIMER_PULSE outside SHOW_WAIT (and outside INPUT when the timeout is enabled).

Latency:
- START_GAME sampled in IDLE at cycle t gives ADD at t+1 and SHOW at t+2.
- TIMER_GO and first OUT_ENA are high together in cycle t+3, with OUT = RAND sampled at t+1.
- The final correct press takes ADD one cycle later; the next SHOW follows after that.

Arithmetic: cnt, i and SCORE are CNT_W unsigned and never wrap, because cnt is bounded by MAX_LEN.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined:
  - On entry to INPUT and after each correct non-final press: TIMER_GO pulses and the per-press pulse counter clears.
  - Each TIMER_PULSE in INPUT increments the counter.
  - Reaching TIMEOUT_PULSES with no IN_VALID goes to END_LOSE.
  - If IN_VALID and the final TIMER_PULSE arrive in the same cycle, IN_VALID wins.
- Undefined: INPUT waits indefinitely; TIMER_GO is never pulsed in INPUT; the counter logic is absent.

Test Plan:
- Reset, then START_GAME, RAND = 2 → TIMER_GO and OUT_ENA high 3 cycles after START; OUT = 2; BUSY = 1.
- Round 2 with stack {2,1} → exactly 2 TIMER_GO pulses, OUT = 2 then 1; OUT_ENA = 0 after the second TIMER_PULSE.
- Round 2 presses 2 then 3 (stack {2,1}) → LOSE = 1, SCORE = 1, HIGH_SCORE = 1, one HS pulse, BUSY = 0 two cycles later.
- MAX_LEN = 4, all rounds correct → WIN = 1, SCORE = 4, HS pulse. A second game lost at SCORE 2 → HIGH_SCORE stays 4, no HS.
- IN_VALID during SHOW_WAIT and START_GAME mid-game → no state effect. RST_N low in INPUT → all outputs at reset values asynchronously.
- With INPUT_TIMEOUT_EN, TIMEOUT_PULSES = 3: three TIMER_PULSEs with no press → LOSE = 1. IN_VALID coincident with the 3rd pulse → press accepted.
